// File: rtl/cache_pkg.sv
// cache_pkg: constants and types shared by the cache tag store.
//   TAG_WIDTH_DEF / S_INDEX_DEF / NUM_WAYS_DEF : default geometry
//   state_t                                    : flush sequencer states
package cache_pkg;

  localparam int TAG_WIDTH_DEF = 24;
  localparam int S_INDEX_DEF   = 4;
  localparam int NUM_WAYS_DEF  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/cache_tag_way.sv
// cache_tag_way: one way of the tag store (tag, valid, dirty and, optionally,
// parity arrays) with a registered, write-first read port.
// Optional feature macro: CACHE_TAG_STORE_PARITY_EN (adds parity array and perr).
// Ports:
//   clk, rst            clock, async active-high reset (clears valid/dirty only)
//   acc                 access accepted this cycle (read registers load)
//   wr                  write this way at addr (already qualified by acc)
//   addr                set index of the access
//   wtag/wvalid/wdirty  write data
//   clr, clr_addr       flush sweep: clear valid/dirty of set clr_addr
//   rd_tag/rd_valid/rd_dirty  registered read data
//   perr                registered parity mismatch of a valid way (macro only)
module cache_tag_way #(
  parameter int TAG_WIDTH = 24,
  parameter int S_INDEX   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc,
  input  logic                 wr,
  input  logic [S_INDEX-1:0]   addr,
  input  logic [TAG_WIDTH-1:0] wtag,
  input  logic                 wvalid,
  input  logic                 wdirty,
  input  logic                 clr,
  input  logic [S_INDEX-1:0]   clr_addr,
  output logic [TAG_WIDTH-1:0] rd_tag,
  output logic                 rd_valid,
  output logic                 rd_dirty
`ifdef CACHE_TAG_STORE_PARITY_EN
  ,
  output logic                 perr
`endif
);

  localparam int DEPTH = 1 << S_INDEX;

  logic [TAG_WIDTH-1:0] tag_mem [DEPTH];
  logic [DEPTH-1:0]     valid_mem;
  logic [DEPTH-1:0]     dirty_mem;

  logic [TAG_WIDTH-1:0] tag_nx;
  logic                 valid_nx;
  logic                 dirty_nx;

  // Tag contents survive reset and flush; only state bits are cleared.
  always_ff @(posedge clk) begin
    if (wr) tag_mem[addr] <= wtag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_mem <= '0;
      dirty_mem <= '0;
    end else begin
      if (clr) begin
        valid_mem[clr_addr] <= 1'b0;
        dirty_mem[clr_addr] <= 1'b0;
      end
      if (wr) begin
        valid_mem[addr] <= wvalid;
        dirty_mem[addr] <= wdirty;
      end
    end
  end

  // Write-first: a same-cycle write is what the read returns.
  always_comb begin
    tag_nx   = wr ? wtag   : tag_mem[addr];
    valid_nx = wr ? wvalid : valid_mem[addr];
    dirty_nx = wr ? wdirty : dirty_mem[addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_tag   <= '0;
      rd_valid <= 1'b0;
      rd_dirty <= 1'b0;
    end else if (acc) begin
      rd_tag   <= tag_nx;
      rd_valid <= valid_nx;
      rd_dirty <= dirty_nx;
    end
  end

`ifdef CACHE_TAG_STORE_PARITY_EN
  logic [DEPTH-1:0] par_mem;
  logic             par_nx;

  always_ff @(posedge clk) begin
    if (wr) par_mem[addr] <= ^wtag;
  end

  assign par_nx = wr ? ^wtag : par_mem[addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      perr <= 1'b0;
    else if (acc) perr <= valid_nx & ((^tag_nx) != par_nx);
  end
`endif

endmodule

// File: rtl/cache_tag_store.sv
// cache_tag_store: set-associative tag store with per-way write enables,
// registered write-first read, tag-compare hit vector and a flush sweep.
// Optional feature macro: CACHE_TAG_STORE_PARITY_EN (even parity per way,
// parity_err output).
// Ports:
//   clk, rst        clock, async active-high reset
//   en, addr        access request and set index
//   we              per-way write enable
//   wtag/wvalid/wdirty  data written to enabled ways
//   lookup_tag      tag compared against the accessed set (registered)
//   flush           start invalidation sweep of all sets
//   rd_tag/rd_valid/rd_dirty  per-way read data, way 0 in the LSBs
//   hit             per-way valid and tag match
//   busy            flush sweep in progress
//   parity_err      parity mismatch on a valid way (macro only)
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | accepting accesses; flush request starts a sweep
// ST_FLUSH | clearing set cnt each cycle; accesses ignored, busy=1
module cache_tag_store
  import cache_pkg::*;
#(
  parameter int TAG_WIDTH = TAG_WIDTH_DEF,
  parameter int S_INDEX   = S_INDEX_DEF,
  parameter int NUM_WAYS  = NUM_WAYS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [S_INDEX-1:0]            addr,
  input  logic [NUM_WAYS-1:0]           we,
  input  logic [TAG_WIDTH-1:0]          wtag,
  input  logic                          wvalid,
  input  logic                          wdirty,
  input  logic [TAG_WIDTH-1:0]          lookup_tag,
  input  logic                          flush,
  output logic [NUM_WAYS*TAG_WIDTH-1:0] rd_tag,
  output logic [NUM_WAYS-1:0]           rd_valid,
  output logic [NUM_WAYS-1:0]           rd_dirty,
  output logic [NUM_WAYS-1:0]           hit,
  output logic                          busy
`ifdef CACHE_TAG_STORE_PARITY_EN
  ,
  output logic                          parity_err
`endif
);

  localparam logic [S_INDEX-1:0] CNT_LAST = '1;

  state_t               state;
  logic [S_INDEX-1:0]   cnt;
  logic [TAG_WIDTH-1:0] lookup_q;
  logic                 acc;
  logic                 clr;

  // Flush wins over a same-cycle access; nothing is accepted mid-sweep.
  assign acc = en & (state == ST_IDLE) & ~flush;
  assign clr = (state == ST_FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flush) begin
            state <= ST_FLUSH;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      lookup_q <= '0;
    else if (acc) lookup_q <= lookup_tag;
  end

`ifdef CACHE_TAG_STORE_PARITY_EN
  logic [NUM_WAYS-1:0] way_perr;
  assign parity_err = |way_perr;
`endif

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    cache_tag_way #(
      .TAG_WIDTH (TAG_WIDTH),
      .S_INDEX   (S_INDEX)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .acc      (acc),
      .wr       (acc & we[w]),
      .addr     (addr),
      .wtag     (wtag),
      .wvalid   (wvalid),
      .wdirty   (wdirty),
      .clr      (clr),
      .clr_addr (cnt),
      .rd_tag   (rd_tag[w*TAG_WIDTH +: TAG_WIDTH]),
      .rd_valid (rd_valid[w]),
      .rd_dirty (rd_dirty[w])
`ifdef CACHE_TAG_STORE_PARITY_EN
      ,
      .perr     (way_perr[w])
`endif
    );

    assign hit[w] = rd_valid[w] & (rd_tag[w*TAG_WIDTH +: TAG_WIDTH] == lookup_q);
  end

endmodule

// File: tb/tb_cache_tag_store.sv
module tb_cache_tag_store;

  localparam int TW = 24;
  localparam int SI = 4;
  localparam int NW = 4;
  localparam int NS = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [SI-1:0]    addr;
  logic [NW-1:0]    we;
  logic [TW-1:0]    wtag;
  logic             wvalid;
  logic             wdirty;
  logic [TW-1:0]    lookup_tag;
  logic             flush;
  logic [NW*TW-1:0] rd_tag;
  logic [NW-1:0]    rd_valid;
  logic [NW-1:0]    rd_dirty;
  logic [NW-1:0]    hit;
  logic             busy;
  logic             parity_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_tag_store #(.TAG_WIDTH(TW), .S_INDEX(SI), .NUM_WAYS(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .addr       (addr),
    .we         (we),
    .wtag       (wtag),
    .wvalid     (wvalid),
    .wdirty     (wdirty),
    .lookup_tag (lookup_tag),
    .flush      (flush),
    .rd_tag     (rd_tag),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .hit        (hit),
    .busy       (busy)
`ifdef CACHE_TAG_STORE_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

`ifndef CACHE_TAG_STORE_PARITY_EN
  assign parity_err = 1'b0;
`endif

  typedef struct {
    logic [NW*TW-1:0] tag;
    logic [NW*TW-1:0] mask;
    logic [NW-1:0]    valid;
    logic [NW-1:0]    dirty;
    logic [NW-1:0]    hit;
    logic             perr;
  } exp_t;

  // Reference model of the store.
  logic [TW-1:0] m_tag   [NS][NW];
  bit            m_known [NS][NW];
  bit            m_valid [NS][NW];
  bit            m_dirty [NS][NW];
  bit            m_bad   [NS][NW];

  exp_t sb[$];
  exp_t last_exp;

  task automatic model_invalidate();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
  endtask

  task automatic zero_last();
    last_exp.tag   = '0;
    last_exp.mask  = '1;
    last_exp.valid = '0;
    last_exp.dirty = '0;
    last_exp.hit   = '0;
    last_exp.perr  = 1'b0;
  endtask

  // Drives one access, predicts the result into the scoreboard, then pops
  // and compares it against the DUT one edge later.
  task automatic access(input logic [SI-1:0] a, input logic [NW-1:0] w,
                        input logic [TW-1:0] t, input logic wv, input logic wd,
                        input logic [TW-1:0] lt, input string nm);
    exp_t e;
    exp_t g;
    @(negedge clk);
    en = 1'b1; addr = a; we = w; wtag = t; wvalid = wv; wdirty = wd;
    lookup_tag = lt; flush = 1'b0;
    e.perr = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (w[i]) begin
        m_tag[a][i] = t; m_known[a][i] = 1; m_valid[a][i] = wv;
        m_dirty[a][i] = wd; m_bad[a][i] = 0;
      end
      e.tag[i*TW +: TW]  = m_known[a][i] ? m_tag[a][i] : '0;
      e.mask[i*TW +: TW] = m_known[a][i] ? {TW{1'b1}} : {TW{1'b0}};
      e.valid[i] = m_valid[a][i];
      e.dirty[i] = m_dirty[a][i];
      e.hit[i]   = m_valid[a][i] && (m_tag[a][i] == lt);
      if (m_valid[a][i] && m_bad[a][i]) e.perr = 1'b1;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    en = 1'b0; we = '0;
    g = sb.pop_front();
    checks++;
    if ((rd_tag & g.mask) !== (g.tag & g.mask)) begin
      failures++;
      $display("FAIL %s rd_tag got=%h exp=%h", nm, rd_tag & g.mask, g.tag & g.mask);
    end
    checks++;
    if (rd_valid !== g.valid) begin
      failures++;
      $display("FAIL %s rd_valid got=%b exp=%b", nm, rd_valid, g.valid);
    end
    checks++;
    if (rd_dirty !== g.dirty) begin
      failures++;
      $display("FAIL %s rd_dirty got=%b exp=%b", nm, rd_dirty, g.dirty);
    end
    checks++;
    if (hit !== g.hit) begin
      failures++;
      $display("FAIL %s hit got=%b exp=%b", nm, hit, g.hit);
    end
`ifdef CACHE_TAG_STORE_PARITY_EN
    checks++;
    if (parity_err !== g.perr) begin
      failures++;
      $display("FAIL %s parity_err got=%b exp=%b", nm, parity_err, g.perr);
    end
`endif
    last_exp = g;
  endtask

  task automatic test_reset();
    en = 0; addr = '0; we = '0; wtag = '0; wvalid = 0; wdirty = 0;
    lookup_tag = '0; flush = 0;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        m_tag[s][w] = '0; m_known[s][w] = 0; m_bad[s][w] = 0;
      end
    model_invalidate();
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rd_valid !== '0 || hit !== '0 || rd_tag !== '0 ||
        rd_dirty !== '0 || parity_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b valid=%b hit=%b tag=%h exp all zero",
               busy, rd_valid, hit, rd_tag);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    zero_last();
    access(4'd5, 4'b0000, '0, 0, 0, '0, "reset_read5");
    access(4'd0, 4'b0000, '0, 0, 0, '0, "reset_read0");
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_write_hit();
    access(4'd3, 4'b0010, 24'hABCDEF, 1, 0, 24'hABCDEF, "write_hit");
    access(4'd3, 4'b0001, 24'h111111, 1, 1, 24'hABCDEF, "partial_write");
    access(4'd3, 4'b0000, '0, 0, 0, 24'h111111, "readback_way0_hit");
    access(4'd3, 4'b0100, 24'h222222, 0, 1, 24'h222222, "write_invalid_nohit");
  endtask

  task automatic test_hold();
    @(negedge clk);
    en = 1'b0; addr = 4'd9; we = 4'b1111; wtag = 24'h5A5A5A; wvalid = 1;
    lookup_tag = 24'h000000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rd_valid !== last_exp.valid || hit !== last_exp.hit ||
        (rd_tag & last_exp.mask) !== (last_exp.tag & last_exp.mask)) begin
      failures++;
      $display("FAIL hold_idle got valid=%b hit=%b exp valid=%b hit=%b",
               rd_valid, hit, last_exp.valid, last_exp.hit);
    end
    we = '0;
    access(4'd9, 4'b0000, '0, 0, 0, '0, "hold_no_write_set9");
  endtask

  task automatic fill_all(input logic [7:0] salt);
    for (int s = 0; s < NS; s++)
      access(s[SI-1:0], 4'b1111, {salt, 12'h0, s[3:0], 4'h0} ^ {$urandom_range(0, 255), 16'h0},
             1, s[0], '0, "fill");
  endtask

  task automatic wait_sweep(input string nm, output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    if (n >= 100) begin
      failures++;
      $display("FAIL %s sweep_timeout busy still %b after %0d cycles", nm, busy, n);
    end
  endtask

  task automatic test_fill_flush();
    int n;
    fill_all(8'hC3);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wait_sweep("flush", n);
    checks++;
    if (n != NS) begin
      failures++;
      $display("FAIL flush_busy_cycles got=%0d exp=%0d", n, NS);
    end
    checks++;
    if (rd_valid !== last_exp.valid) begin
      failures++;
      $display("FAIL flush_outputs_hold got=%b exp=%b", rd_valid, last_exp.valid);
    end
    model_invalidate();
    for (int s = 0; s < NS; s++)
      access(s[SI-1:0], 4'b0000, '0, 0, 0, m_tag[s][1], "post_flush_read");
  endtask

  task automatic test_flush_priority();
    int n;
    logic [NW-1:0] held;
    held = last_exp.valid;
    @(negedge clk);
    flush = 1'b1; en = 1'b1; we = 4'b1111; addr = 4'd7; wtag = 24'hFEEDED;
    wvalid = 1; wdirty = 1; lookup_tag = 24'hFEEDED;
    @(posedge clk);
    #1;
    flush = 1'b0;
    addr = 4'd2; wtag = 24'h0BAD00;
    @(posedge clk);
    #1;
    flush = 1'b1;
    checks++;
    if (rd_valid !== held || busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_ignores_access got valid=%b busy=%b exp valid=%b busy=1",
               rd_valid, busy, held);
    end
    wait_sweep("flush_prio", n);
    en = 1'b0; we = '0; flush = 1'b0;
    checks++;
    if (n != NS - 1) begin
      failures++;
      $display("FAIL flush_prio_busy_cycles got=%0d exp=%0d", n, NS - 1);
    end
    model_invalidate();
    access(4'd7, 4'b0000, '0, 0, 0, 24'hFEEDED, "flush_prio_set7");
    access(4'd2, 4'b0000, '0, 0, 0, 24'h0BAD00, "busy_write_dropped_set2");
  endtask

  task automatic test_reset_mid_flush();
    fill_all(8'h3C);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rd_valid !== '0 || hit !== '0 || rd_tag !== '0) begin
      failures++;
      $display("FAIL reset_mid_flush got busy=%b valid=%b hit=%b exp all zero",
               busy, rd_valid, hit);
    end
    @(negedge clk);
    rst = 1'b0;
    model_invalidate();
    zero_last();
    for (int s = 0; s < NS; s++)
      access(s[SI-1:0], 4'b0000, '0, 0, 0, m_tag[s][2], "after_reset_read");
    access(4'd12, 4'b1000, 24'h777777, 1, 1, 24'h777777, "after_reset_write");
  endtask

  task automatic test_back_to_back();
    logic [SI-1:0] a;
    logic [NW-1:0] w;
    logic [TW-1:0] t;
    logic [TW-1:0] lt;
    for (int k = 0; k < 40; k++) begin
      a = SI'($urandom_range(0, NS - 1));
      w = ($urandom_range(0, 1) == 0) ? '0 : NW'($urandom);
      t = TW'($urandom);
      lt = ($urandom_range(0, 2) == 0) ? TW'($urandom) : m_tag[a][$urandom_range(0, NW - 1)];
      if (w != '0 && $urandom_range(0, 1) == 0) lt = t;
      access(a, w, t, 1'($urandom), 1'($urandom), lt, "back_to_back");
    end
  endtask

`ifdef CACHE_TAG_STORE_PARITY_EN
  task automatic test_parity();
    access(4'd3, 4'b0010, 24'h123456, 1, 0, 24'h123456, "parity_write");
    dut.g_way[1].u_way.tag_mem[3] = dut.g_way[1].u_way.tag_mem[3] ^ 24'h000010;
    m_tag[3][1] = m_tag[3][1] ^ 24'h000010;
    m_bad[3][1] = 1;
    access(4'd3, 4'b0000, '0, 0, 0, 24'h123456, "parity_flip_read");
    access(4'd3, 4'b0010, 24'h654321, 1, 0, 24'h654321, "parity_rewrite");
  endtask
`endif

  initial begin
    test_reset();
    test_write_hit();
    test_hold();
    test_fill_flush();
    test_flush_priority();
    test_reset_mid_flush();
    test_back_to_back();
`ifdef CACHE_TAG_STORE_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
